mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 13, the word-address width of the shared BRAM.
REQ-002 SHALL have parameter RAM_BUS_WIDTH, default 32, the data width of the shared BRAM.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port a_req  input  1  instruction-fetch read request, held with a_addr until a_gnt.
REQ-006 SHALL have port a_addr  input  RAM_ADDR_WIDTH  instruction-fetch word address.
REQ-007 SHALL have ports a_gnt, a_rvalid  output  1 each  fetch accepted this cycle; fetch data valid this cycle.
REQ-008 SHALL have port a_rdata  output  RAM_BUS_WIDTH  fetch read data.
REQ-009 SHALL have port b_req  input  1  load/store request, held with b_we, b_addr and b_wdata until b_gnt.
REQ-010 SHALL have ports b_we  input  4  byte-write mask, 0 = read; b_addr  input  RAM_ADDR_WIDTH; b_wdata  input  RAM_BUS_WIDTH.
REQ-011 SHALL have ports b_gnt, b_rvalid  output  1 each; b_rdata  output  RAM_BUS_WIDTH.
REQ-012 SHALL have ports mem_rd  output  1, mem_we  output  4, mem_addr  output  RAM_ADDR_WIDTH, mem_wdata  output  RAM_BUS_WIDTH, all driving the BRAM.
REQ-013 SHALL have port mem_rdata  input  RAM_BUS_WIDTH  BRAM registered output, valid one cycle after mem_rd.

Function
REQ-014 SHALL grant at most one requester per cycle; a_gnt and b_gnt are never both 1.
REQ-015 SHALL, with only one req high, grant that requester in the same cycle.
REQ-016 SHALL resolve a tie round-robin: grant the requester not granted most recently; a last_grant register updates only on a grant.
REQ-017 SHALL, in the grant cycle T, drive mem_addr from the winner and set mem_rd=1 for A, or for B with b_we=0; B with b_we!=0 gives mem_rd=0, mem_we=b_we, mem_wdata=b_wdata.
REQ-018 SHALL, with no grant, drive mem_rd=0 and mem_we=0; mem_addr and mem_wdata are don't-care.
REQ-019 SHALL track the response owner in a registered state: RESP_NONE, RESP_A or RESP_B, loaded at each edge from the grant of that cycle.
REQ-020 SHALL assert x_rvalid for exactly one cycle, T+1, for every grant to x, including B writes as the completion ack.
REQ-021 SHALL wire a_rdata and b_rdata directly to mem_rdata; data is meaningful only with the matching rvalid.
REQ-022 SHALL permit back-to-back grants: a new grant in cycle T+1 overlaps the response of T; one access per cycle under sustained load.
REQ-023 SHALL, with both req held continuously, alternate grants A,B,A,B after the first grant.
REQ-024 SHALL not buffer requests; an ungranted requester keeps req high, and dropping req before gnt withdraws it without side effects.
REQ-025 SHALL make grant decisions only from current req inputs and last_grant; a combinational path from req to gnt and mem_* is allowed.

Reset
REQ-026 SHALL, while rst_n=0, force a_gnt=b_gnt=0, mem_rd=0 and mem_we=0 combinationally, regardless of req.
REQ-027 SHALL, on a clock edge with rst_n=0, set owner=RESP_NONE and last_grant=A, so B wins the first tie after reset.
REQ-028 SHALL, in the first cycle after reset release, drive a_rvalid=b_rvalid=0.
REQ-029 SHALL, when reset is asserted in a grant cycle, drop that grant and give no rvalid; a B write gated that cycle does not reach the BRAM.

Verification
REQ-030 SHALL cover: reset, then a_req=1, a_addr=0x010 with BRAM word 0x010=0x00500093 -> a_gnt=1 and mem_rd=1, mem_addr=0x010 in the same cycle; next cycle a_rvalid=1, a_rdata=0x00500093.
REQ-031 SHALL cover: b_req=1, b_we=4'b0011, b_addr=0x100, b_wdata=0xAABBCCDD over word 0x11223344 -> mem_we=4'b0011 and b_rvalid next cycle; a B read of 0x100 then returns 0x1122CCDD.
REQ-032 SHALL cover: first cycle after reset with a_req=b_req=1 held for 4 cycles -> grants B,A,B,A; each rvalid follows its grant by one cycle; gnt never both 1.
REQ-033 SHALL cover: a_req=1 held and b_req pulsed for one cycle in a cycle where A wins the tie -> B is never granted and no b_rvalid occurs.
REQ-034 SHALL cover: rst_n=0 in the cycle of a B write grant -> mem_we=0, no b_rvalid, BRAM unchanged; after release outputs idle until a new req.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one registered-output BRAM between an instruction-fetch
// port (A) and a load/store port (B); one access per cycle, round-robin on ties.
//
// state     | meaning
// RESP_NONE | no access was issued last cycle, no rvalid this cycle
// RESP_A    | last cycle's access belonged to A, a_rvalid this cycle
// RESP_B    | last cycle's access belonged to B, b_rvalid this cycle
module mem_arbiter #(
    parameter int RAM_ADDR_WIDTH = 13,
    parameter int RAM_BUS_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      a_req,
    input  logic [RAM_ADDR_WIDTH-1:0] a_addr,
    output logic                      a_gnt,
    output logic                      a_rvalid,
    output logic [RAM_BUS_WIDTH-1:0]  a_rdata,

    input  logic                      b_req,
    input  logic [3:0]                b_we,
    input  logic [RAM_ADDR_WIDTH-1:0] b_addr,
    input  logic [RAM_BUS_WIDTH-1:0]  b_wdata,
    output logic                      b_gnt,
    output logic                      b_rvalid,
    output logic [RAM_BUS_WIDTH-1:0]  b_rdata,

    output logic                      mem_rd,
    output logic [3:0]                mem_we,
    output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
    output logic [RAM_BUS_WIDTH-1:0]  mem_wdata,
    input  logic [RAM_BUS_WIDTH-1:0]  mem_rdata
);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_A    = 2'd1,
        RESP_B    = 2'd2
    } owner_e;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    owner_e owner_q, owner_d;
    grant_e last_grant_q, last_grant_d;

    always_comb begin
        a_gnt        = 1'b0;
        b_gnt        = 1'b0;
        owner_d      = RESP_NONE;
        last_grant_d = last_grant_q;

        // Reset gates grants combinationally so nothing reaches the BRAM.
        if (rst_n) begin
            if (a_req && b_req) begin
                if (last_grant_q == GRANT_A) begin
                    b_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end

        mem_rd    = a_gnt | (b_gnt & (b_we == 4'b0000));
        mem_we    = b_gnt ? b_we : 4'b0000;
        mem_addr  = b_gnt ? b_addr : a_addr;
        mem_wdata = b_wdata;

        if (a_gnt) begin
            owner_d      = RESP_A;
            last_grant_d = GRANT_A;
        end else if (b_gnt) begin
            owner_d      = RESP_B;
            last_grant_d = GRANT_B;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q      <= RESP_NONE;
            last_grant_q <= GRANT_A;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign a_rvalid = (owner_q == RESP_A);
    assign b_rvalid = (owner_q == RESP_B);
    assign a_rdata  = mem_rdata;
    assign b_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: BRAM model, directed scenarios with literal expectations,
// then random traffic checked every cycle against a request/response reference model.
module tb_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_rdata;
    logic          b_req, b_gnt, b_rvalid;
    logic [3:0]    b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_rd;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.RAM_ADDR_WIDTH(AW), .RAM_BUS_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // BRAM with registered read data; bd_* is a backdoor preload port.
    logic [DW-1:0] bram [0:(1<<AW)-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= bram[mem_addr];
        for (int i = 0; i < 4; i++)
            if (mem_we[i]) bram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        if (bd_we) bram[bd_addr] <= bd_data;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what memory should hold, who was served last, what is owed next cycle.
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    bit            last_was_b;
    bit            owe_a, owe_b, owe_data_valid;
    logic [DW-1:0] owe_data;
    bit            g_a, g_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Called at the negedge: compare everything against the model, commit, move past the edge.
    task automatic advance();
        bit            want_a, want_b, win_a, win_b, b_write;
        logic [AW-1:0] addr;
        chk("a_rvalid", 32'(a_rvalid), 32'(owe_a));
        chk("b_rvalid", 32'(b_rvalid), 32'(owe_b));
        if (owe_a && owe_data_valid) chk("a_rdata", a_rdata, owe_data);
        if (owe_b && owe_data_valid) chk("b_rdata", b_rdata, owe_data);

        want_a = rst_n && a_req;
        want_b = rst_n && b_req;
        // Contested: serve whoever was not served most recently.
        win_a  = want_a && (!want_b || last_was_b);
        win_b  = want_b && !win_a;
        b_write = win_b && (b_we != 4'b0000);
        addr   = win_b ? b_addr : a_addr;

        chk("a_gnt", 32'(a_gnt), 32'(win_a));
        chk("b_gnt", 32'(b_gnt), 32'(win_b));
        chk("mem_rd", 32'(mem_rd), 32'((win_a || win_b) && !b_write));
        chk("mem_we", 32'(mem_we), 32'(b_write ? b_we : 4'b0000));
        if (win_a || win_b) chk("mem_addr", 32'(mem_addr), 32'(addr));
        if (b_write) chk("mem_wdata", mem_wdata, b_wdata);

        owe_a          = win_a;
        owe_b          = win_b;
        owe_data_valid = (win_a || win_b) && !b_write;
        owe_data       = shadow[addr];
        if (b_write)
            for (int i = 0; i < 4; i++)
                if (b_we[i]) shadow[b_addr][8*i +: 8] = b_wdata[8*i +: 8];
        if (win_a) last_was_b = 1'b0;
        if (win_b) last_was_b = 1'b1;
        if (!rst_n) last_was_b = 1'b0;
        g_a = win_a;
        g_b = win_b;
        @(posedge clk);
        #1;
    endtask

    task automatic backdoor(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bd_we   = 1'b1;
        bd_addr = addr;
        bd_data = data;
        shadow[addr] = data;
        settle();
        chk("rst_a_gnt", 32'(a_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        advance();
        bd_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_addr = '0;
        b_req = 1'b0; b_we = 4'h0; b_addr = '0; b_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        last_was_b = 1'b0; owe_a = 1'b0; owe_b = 1'b0; owe_data_valid = 1'b0;
        owe_data = '0; g_a = 1'b0; g_b = 1'b0;
        for (int i = 0; i < (1<<AW); i++) shadow[i] = '0;
        @(posedge clk); #1;

        // Reset with both requesters active, including a B write: nothing may be granted.
        a_req = 1'b1; b_req = 1'b1; b_we = 4'hF; b_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 16; i++) backdoor(AW'(i), $urandom);
        backdoor(AW'('h010), 32'h0050_0093);
        backdoor(AW'('h100), 32'h1122_3344);
        backdoor(AW'('h200), 32'h5555_5555);

        a_req = 1'b0; b_req = 1'b0; rst_n = 1'b1;
        settle();
        chk("post_rst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("post_rst_b_rvalid", 32'(b_rvalid), 32'd0);
        advance();

        // Instruction fetch.
        a_req = 1'b1; a_addr = AW'('h010);
        settle();
        chk("fetch_gnt", 32'(a_gnt), 32'd1);
        chk("fetch_rd", 32'(mem_rd), 32'd1);
        chk("fetch_addr", 32'(mem_addr), 32'h010);
        advance();
        a_req = 1'b0;
        settle();
        chk("fetch_rvalid", 32'(a_rvalid), 32'd1);
        chk("fetch_rdata", a_rdata, 32'h0050_0093);
        advance();

        // Partial store then read back.
        b_req = 1'b1; b_we = 4'b0011; b_addr = AW'('h100); b_wdata = 32'hAABB_CCDD;
        settle();
        chk("store_we", 32'(mem_we), 32'h3);
        advance();
        b_req = 1'b0;
        settle();
        chk("store_ack", 32'(b_rvalid), 32'd1);
        advance();
        b_req = 1'b1; b_we = 4'b0000;
        settle();
        advance();
        b_req = 1'b0;
        settle();
        chk("load_rvalid", 32'(b_rvalid), 32'd1);
        chk("load_rdata", b_rdata, 32'h1122_CCDD);
        advance();

        // Sustained contention right after reset: B, A, B, A.
        rst_n = 1'b0;
        settle();
        advance();
        rst_n = 1'b1; a_req = 1'b1; a_addr = AW'(3); b_req = 1'b1; b_we = 4'h0; b_addr = AW'(5);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("alt_b_gnt", 32'(b_gnt), 32'((k % 2) == 0));
            chk("alt_a_gnt", 32'(a_gnt), 32'((k % 2) == 1));
            advance();
        end
        a_req = 1'b0; b_req = 1'b0;
        settle();
        chk("alt_tail_a_rvalid", 32'(a_rvalid), 32'd1);
        advance();

        // B serves alone, then a one-cycle B pulse loses the tie to A and vanishes.
        b_req = 1'b1;
        settle();
        advance();
        a_req = 1'b1; b_addr = AW'(7);
        settle();
        chk("pulse_a_gnt", 32'(a_gnt), 32'd1);
        chk("pulse_b_gnt", 32'(b_gnt), 32'd0);
        advance();
        b_req = 1'b0;
        settle();
        chk("pulse_no_b_rvalid", 32'(b_rvalid), 32'd0);
        advance();
        a_req = 1'b0;
        settle();
        advance();

        // Reset during a B write: no write, no ack, idle afterwards, word untouched.
        b_req = 1'b1; b_we = 4'hF; b_addr = AW'('h200); b_wdata = 32'h0;
        rst_n = 1'b0;
        settle();
        chk("rstw_mem_we", 32'(mem_we), 32'd0);
        chk("rstw_b_gnt", 32'(b_gnt), 32'd0);
        advance();
        rst_n = 1'b1; b_req = 1'b0;
        settle();
        chk("rstw_b_rvalid", 32'(b_rvalid), 32'd0);
        chk("rstw_idle_rd", 32'(mem_rd), 32'd0);
        advance();
        b_req = 1'b1; b_we = 4'h0;
        settle();
        advance();
        b_req = 1'b0;
        settle();
        chk("rstw_word", b_rdata, 32'h5555_5555);
        advance();

        // Random traffic with held/withdrawn requests and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if (a_req && !g_a) begin
                if ($urandom_range(0, 9) == 0) a_req = 1'b0;
            end else begin
                a_req  = ($urandom_range(0, 2) != 0);
                a_addr = AW'($urandom_range(0, 15));
            end
            if (b_req && !g_b) begin
                if ($urandom_range(0, 9) == 0) b_req = 1'b0;
            end else begin
                b_req   = ($urandom_range(0, 2) != 0);
                b_addr  = AW'($urandom_range(0, 15));
                b_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                b_wdata = $urandom;
            end
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
